// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - shared sizing helpers and types for the multi-tap delay line
package delay_line_pkg;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    typedef int unsigned tap_idx_t;

endpackage

// File: rtl/dp_ram_bank.sv
// rtl/dp_ram_bank.sv - simple dual-port RAM bank, one write port and one registered read port
module dp_ram_bank
    import delay_line_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DEPTH = depth(ADDRESS_WIDTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Read returns the pre-write contents on an address collision; the top bypasses that case.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/delay_line_ram.sv
// rtl/delay_line_ram.sv - multi-tap circular delay line over replicated block RAM banks
module delay_line_ram
    import delay_line_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_CH        = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic [NUM_CH*ADDRESS_WIDTH-1:0] offset,
    output logic [NUM_CH*DATA_WIDTH-1:0]    dout,
    output logic [NUM_CH-1:0]               dout_valid,
    output logic [ADDRESS_WIDTH-1:0]        fill
);

    localparam int                     AW       = ADDRESS_WIDTH;
    localparam int                     DW       = DATA_WIDTH;
    localparam int                     DEPTH    = depth(AW);
    localparam logic [AW-1:0]          FILL_MAX = AW'(DEPTH - 1);

    logic [AW-1:0]     wr_ptr;
    logic              live;
    logic [DW-1:0]     din_q;
    logic [NUM_CH-1:0] byp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            fill       <= '0;
            live       <= 1'b0;
            din_q      <= '0;
            byp_q      <= '0;
            dout_valid <= '0;
        end else begin
            dout_valid <= '0;
            if (en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
                live  <= 1'b1;
                din_q <= din;
                // Validity uses the fill level before this strobe's write.
                for (int k = 0; k < NUM_CH; k++) begin
                    byp_q[k]      <= (offset[k*AW +: AW] == '0);
                    dout_valid[k] <= (fill >= offset[k*AW +: AW]);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_tap
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] ram_q;

        assign rd_addr = wr_ptr - offset[k*AW +: AW];

        dp_ram_bank #(
            .ADDRESS_WIDTH (AW),
            .DATA_WIDTH    (DW)
        ) u_bank (
            .clk   (clk),
            .we    (en),
            .waddr (wr_ptr),
            .wdata (din),
            .re    (en),
            .raddr (rd_addr),
            .rdata (ram_q)
        );

        // live masks the unreset RAM read register until the first post-reset strobe.
        assign dout[k*DW +: DW] = !live    ? '0    :
                                  byp_q[k] ? din_q : ram_q;
    end

endmodule

// File: tb/tb_delay_line_ram.sv
// tb/tb_delay_line_ram.sv - directed and scoreboard checks for delay_line_ram
module tb_delay_line_ram;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [DW-1:0]     din = '0;
    logic [NCH*AW-1:0] offset = '0;
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    dout_valid;
    logic [AW-1:0]     fill;

    int tests = 0;
    int fails = 0;

    delay_line_ram #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_CH        (NCH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .offset     (offset),
        .dout       (dout),
        .dout_valid (dout_valid),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic e, input logic [DW-1:0] d);
        @(negedge clk);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic set_off(input int k, input logic [AW-1:0] v);
        offset[k*AW +: AW] = v;
    endtask

    task automatic test_reset();
        @(negedge clk);
        en    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (dout !== '0) begin
            fails++;
            $display("FAIL reset_dout got=%h exp=0", dout);
        end
        tests++;
        if (dout_valid !== '0) begin
            fails++;
            $display("FAIL reset_valid got=%b exp=0", dout_valid);
        end
        tests++;
        if (fill !== '0) begin
            fails++;
            $display("FAIL reset_fill got=%0d exp=0", fill);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_delay();
        test_reset();
        set_off(0, 4'd3);
        set_off(1, 4'd0);
        for (int n = 0; n <= 10; n++) begin
            cycle(1'b1, 8'(n + 1));
            tests++;
            if (dout_valid[0] !== (n >= 3)) begin
                fails++;
                $display("FAIL basic_valid0 n=%0d got=%b exp=%b", n, dout_valid[0], (n >= 3));
            end
            if (n >= 3) begin
                tests++;
                if (dout[7:0] !== 8'(n - 2)) begin
                    fails++;
                    $display("FAIL basic_dout0 n=%0d got=%0d exp=%0d", n, dout[7:0], n - 2);
                end
            end
        end
    endtask

    task automatic test_wrap_bypass();
        test_reset();
        set_off(0, 4'd15);
        set_off(1, 4'd0);
        for (int n = 0; n < 40; n++) begin
            cycle(1'b1, 8'(n + 1));
            tests++;
            if (dout[15:8] !== 8'(n + 1) || dout_valid[1] !== 1'b1) begin
                fails++;
                $display("FAIL bypass_dout1 n=%0d got=%0d/%b exp=%0d/1", n, dout[15:8], dout_valid[1], n + 1);
            end
            tests++;
            if (dout_valid[0] !== (n >= 15)) begin
                fails++;
                $display("FAIL wrap_valid0 n=%0d got=%b exp=%b", n, dout_valid[0], (n >= 15));
            end
            if (n >= 15) begin
                tests++;
                if (dout[7:0] !== 8'(n - 14)) begin
                    fails++;
                    $display("FAIL wrap_dout0 n=%0d got=%0d exp=%0d", n, dout[7:0], n - 14);
                end
            end
            tests++;
            if (fill !== 4'((n + 1 > 15) ? 15 : n + 1)) begin
                fails++;
                $display("FAIL wrap_fill n=%0d got=%0d exp=%0d", n, fill, (n + 1 > 15) ? 15 : n + 1);
            end
        end
    endtask

    task automatic test_en_gaps();
        test_reset();
        set_off(0, 4'd2);
        set_off(1, 4'd0);
        for (int n = 0; n < 5; n++) begin
            cycle(1'b1, 8'(n + 1));
        end
        cycle(1'b1, 8'd6);
        tests++;
        if (dout[7:0] !== 8'd4 || dout_valid[0] !== 1'b1) begin
            fails++;
            $display("FAIL gap_first got=%0d/%b exp=4/1", dout[7:0], dout_valid[0]);
        end
        for (int g = 0; g < 2; g++) begin
            cycle(1'b0, 8'hEE);
            tests++;
            if (dout[7:0] !== 8'd4 || dout_valid !== 2'b00 || fill !== 4'd6) begin
                fails++;
                $display("FAIL gap_hold g=%0d got=%0d/%b/%0d exp=4/00/6", g, dout[7:0], dout_valid, fill);
            end
        end
        cycle(1'b1, 8'd7);
        tests++;
        if (dout[7:0] !== 8'd5 || dout_valid[0] !== 1'b1 || fill !== 4'd7) begin
            fails++;
            $display("FAIL gap_resume got=%0d/%b/%0d exp=5/1/7", dout[7:0], dout_valid[0], fill);
        end
        set_off(0, 4'd1);
        cycle(1'b1, 8'd8);
        tests++;
        if (dout[7:0] !== 8'd7 || dout[15:8] !== 8'd8) begin
            fails++;
            $display("FAIL gap_ptr got=%0d/%0d exp=7/8", dout[7:0], dout[15:8]);
        end
    endtask

    task automatic test_mid_reset();
        test_reset();
        set_off(0, 4'd3);
        set_off(1, 4'd0);
        for (int n = 0; n < 10; n++) begin
            cycle(1'b1, 8'(n + 1));
        end
        test_reset();
        for (int n = 0; n <= 4; n++) begin
            cycle(1'b1, 8'(8'h40 + n));
            tests++;
            if (dout_valid[0] !== (n >= 3)) begin
                fails++;
                $display("FAIL rst_valid0 n=%0d got=%b exp=%b", n, dout_valid[0], (n >= 3));
            end
            if (n >= 3) begin
                tests++;
                if (dout[7:0] !== 8'(8'h40 + n - 3)) begin
                    fails++;
                    $display("FAIL rst_dout0 n=%0d got=%h exp=%h", n, dout[7:0], 8'h40 + n - 3);
                end
            end
        end
    endtask

    task automatic test_offset_change();
        test_reset();
        set_off(0, 4'd3);
        set_off(1, 4'd0);
        for (int n = 0; n < 8; n++) begin
            cycle(1'b1, 8'(n + 1));
        end
        set_off(0, 4'd6);
        cycle(1'b1, 8'd9);
        tests++;
        if (dout[7:0] !== 8'd3 || dout_valid[0] !== 1'b1) begin
            fails++;
            $display("FAIL offchg_6 got=%0d/%b exp=3/1", dout[7:0], dout_valid[0]);
        end
        set_off(0, 4'd12);
        for (int n = 9; n <= 13; n++) begin
            cycle(1'b1, 8'(n + 1));
            tests++;
            if (dout_valid[0] !== (n >= 12)) begin
                fails++;
                $display("FAIL offchg_valid n=%0d got=%b exp=%b", n, dout_valid[0], (n >= 12));
            end
            if (n >= 12) begin
                tests++;
                if (dout[7:0] !== 8'(n - 11)) begin
                    fails++;
                    $display("FAIL offchg_dout n=%0d got=%0d exp=%0d", n, dout[7:0], n - 11);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic [AW-1:0] offs[NCH];
        logic [DW-1:0] d;
        int            cnt;
        int            nstrobe;
        int            fmod;
        logic          exp_v;
        test_reset();
        cnt     = 0;
        nstrobe = 0;
        for (int k = 0; k < NCH; k++) begin
            offs[k] = AW'($urandom_range(0, 15));
        end
        while (nstrobe < 1000) begin
            d = DW'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < NCH; k++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        offs[k] = AW'($urandom_range(0, 15));
                    end
                    set_off(k, offs[k]);
                end
                fmod = (cnt > 15) ? 15 : cnt;
                q.push_front(d);
                if (q.size() > 16) begin
                    void'(q.pop_back());
                end
                cnt++;
                nstrobe++;
                cycle(1'b1, d);
                for (int k = 0; k < NCH; k++) begin
                    exp_v = (fmod >= int'(offs[k]));
                    tests++;
                    if (dout_valid[k] !== exp_v) begin
                        fails++;
                        $display("FAIL rnd_valid s=%0d k=%0d got=%b exp=%b", nstrobe, k, dout_valid[k], exp_v);
                    end
                    if (exp_v) begin
                        tests++;
                        if (dout[k*DW +: DW] !== q[offs[k]]) begin
                            fails++;
                            $display("FAIL rnd_dout s=%0d k=%0d got=%h exp=%h", nstrobe, k, dout[k*DW +: DW], q[offs[k]]);
                        end
                    end
                end
            end else begin
                cycle(1'b0, d);
                tests++;
                if (dout_valid !== '0) begin
                    fails++;
                    $display("FAIL rnd_gap_valid s=%0d got=%b exp=0", nstrobe, dout_valid);
                end
            end
        end
        tests++;
        if (fill !== 4'd15) begin
            fails++;
            $display("FAIL rnd_fill got=%0d exp=15", fill);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic_delay();
        test_wrap_bypass();
        test_en_gaps();
        test_mid_reset();
        test_offset_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
